change_dispenser: RTL
=====================

# change_dispenser

Change-return back end for the vending controller. Accepts a packed-BCD change amount (the value the controller shows on its left display after a sale), breaks it greedily into quarters, dimes and nickels, and drives a coin hopper one coin at a time with a pulse/acknowledge handshake. It sits between the vending controller's change output and the physical hopper. Hopper stalls and malformed amounts are reported on a fault flag.

## Interface
- Parameters:
- PULSE_CYCLES, 4: width of each eject pulse in clock cycles (1..15).
- ACK_TIMEOUT, 255: number of WAIT_ACK cycles without `hopper_ack` before lock-up (2..255).
- Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- change_valid  in  1  one-cycle request strobe; sampled only in IDLE.
- change_amount  in  8  packed BCD cents: [7:4] tens 0..9, [3:0] units 0 or 5.
- change_ready  out  1  high only in IDLE.
- eject  out  3  one-hot coin command: 001 nickel, 010 dime, 100 quarter, 000 none.
- hopper_ack  in  1  hopper confirms one coin dropped.
- done  out  1  one-cycle pulse when a request is fully paid.
- remaining  out  5  binary nickels still owed (0..19).
- fault  out  1  sticky error flag.
- q_count, d_count, n_count  out  8 each  coin counters (see Configuration).

## Operation
- On accept, convert the amount to nickels: N = tens*2 + (units==5). Store in `remaining`.
- Illegal amount (tens > 9, or units not 0/5): request dropped, fault set, FSM stays IDLE and keeps accepting requests.
- Amount 0x00: no coins; `done` pulses the next cycle and the FSM stays IDLE.
- Greedy choice in SELECT:
- N >= 5: quarter, subtract 5.
- N >= 2: dime, subtract 2.
- Otherwise: nickel, subtract 1.
- FSM states:
- IDLE: `change_ready`=1. A legal nonzero request moves to SELECT.
- SELECT (1 cycle): latch the coin choice, go to PULSE.
- PULSE: `eject` = chosen coin for exactly PULSE_CYCLES cycles, then WAIT_ACK.
- WAIT_ACK: `eject`=0. On `hopper_ack`, subtract the coin value. Result 0: `done` and go to IDLE. Otherwise go to SELECT.
- WAIT_ACK timeout: ACK_TIMEOUT consecutive cycles with no ack go to FAULT.
- FAULT: `eject`=0, `change_ready`=0, `fault`=1. Exit only through reset.
- Ignored inputs:
- `hopper_ack` outside WAIT_ACK.
- `change_valid` outside IDLE, with no effect on fault.
- `fault` clears only on reset.

## Timing
- Reset values: `change_ready`=1, `eject`=000, `done`=0, `remaining`=0, `fault`=0, all counters 0, state IDLE.
- Reset mid-operation: `eject` drops to 000 asynchronously and any in-progress request is lost.
- `change_valid` at cycle 0:
- SELECT at cycle 1; `change_ready` low from cycle 1.
- `eject` high in cycles 2 .. 1+PULSE_CYCLES.
- WAIT_ACK from cycle 2+PULSE_CYCLES.
- `hopper_ack` sampled high in cycle t:
- `remaining` updates at t+1.
- If `remaining` is now 0: `done`=1 and `change_ready`=1 at t+1.
- Otherwise: SELECT at t+1, next `eject` at t+2.
- Timeout timer clears on WAIT_ACK entry. FAULT is entered on the cycle after the ACK_TIMEOUT-th ack-less WAIT_ACK cycle.
- All outputs are registered.

## Configuration
- CHANGE_DISP_COUNT_EN defined:
- `q_count`/`d_count`/`n_count` increment on each acknowledged coin of their type.
- Counters saturate at 255 and clear only on reset.
- Undefined: the three counter ports are present but tied to 0, and no counter logic is built.

## Test plan
- reset_n low mid-PULSE -> `eject`=000 immediately. After release: `change_ready`=1, `remaining`=0, `fault`=0.
- 0x35 with PULSE_CYCLES=4 and ack 1 cycle into each WAIT_ACK -> `eject` sequence 100, 010; `remaining` 7→2→0; `done` one cycle. With macro: q_count=1, d_count=1.
- 0x95 -> coin sequence Q,Q,Q,D,D, `remaining` 19→14→9→4→2→0, exactly 5 acks, single `done`.
- 0x15 then 0x00 -> D,N then `done`; 0x00 -> `done` the cycle after accept, no `eject`.
- 0x17, then 0xA0 -> `fault`=1, no `eject`, `change_ready` stays 1. A subsequent 0x05 still pays one nickel, and `fault` stays 1.
- 0x10 with no ack -> FAULT exactly ACK_TIMEOUT cycles after WAIT_ACK entry. `change_ready`=0; `fault`=1; further `change_valid`/`hopper_ack` ignored until reset.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Request/hopper bundle for change_dispenser: the master is the vending side and hopper,
// and the slave is the dispenser itself.
interface change_dispenser_if;
  logic       change_valid;
  logic [7:0] change_amount;
  logic       change_ready;
  logic [2:0] eject;
  logic       hopper_ack;
  logic       done;
  logic [4:0] remaining;
  logic       fault;
  logic [7:0] q_count;
  logic [7:0] d_count;
  logic [7:0] n_count;

  modport master (
    output change_valid, change_amount, hopper_ack,
    input  change_ready, eject, done, remaining, fault, q_count, d_count, n_count
  );

  modport slave (
    input  change_valid, change_amount, hopper_ack,
    output change_ready, eject, done, remaining, fault, q_count, d_count, n_count
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy BCD change dispenser: it pays quarters, dimes and nickels one coin at a time
// with a pulse/ack hopper handshake. Define CHANGE_DISP_COUNT_EN to build the coin counters.
module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 255
) (
  input logic clk,
  input logic reset_n,
  change_dispenser_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, WAIT_ACK, FAULT} state_t;

  localparam logic [3:0] PULSE_LAST   = 4'(PULSE_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state;
  logic [2:0] coin;
  logic [2:0] eject;
  logic [3:0] pulse_cnt;
  logic [7:0] ack_timer;
  logic [4:0] remaining;
  logic       ready;
  logic       done;
  logic       fault;

  logic [3:0] tens;
  logic [3:0] units;
  logic       amount_legal;
  logic [4:0] amount_nickels;
  logic [2:0] next_coin;
  logic [4:0] coin_value;
  logic [4:0] remaining_next;
  logic       ack_accepted;

  assign tens           = bus.change_amount[7:4];
  assign units          = bus.change_amount[3:0];
  assign amount_legal   = (tens <= 4'd9) && ((units == 4'd0) || (units == 4'd5));
  assign amount_nickels = {tens, 1'b0} + {4'd0, (units == 4'd5)};
  assign ack_accepted   = (state == WAIT_ACK) && bus.hopper_ack;

  always_comb begin
    next_coin = 3'b001;
    if (remaining >= 5'd5)
      next_coin = 3'b100;
    else if (remaining >= 5'd2)
      next_coin = 3'b010;
  end

  always_comb begin
    coin_value = 5'd1;
    case (coin)
      3'b100:  coin_value = 5'd5;
      3'b010:  coin_value = 5'd2;
      default: coin_value = 5'd1;
    endcase
  end

  assign remaining_next = remaining - coin_value;

  // Eject is registered with the async reset so a reset cuts the hopper drive at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      coin      <= 3'b000;
      eject     <= 3'b000;
      pulse_cnt <= 4'd0;
      ack_timer <= 8'd0;
      remaining <= 5'd0;
      ready     <= 1'b1;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.change_valid) begin
            if (!amount_legal) begin
              fault <= 1'b1;
            end else if (amount_nickels == 5'd0) begin
              remaining <= 5'd0;
              done      <= 1'b1;
            end else begin
              remaining <= amount_nickels;
              ready     <= 1'b0;
              state     <= SELECT;
            end
          end
        end
        SELECT: begin
          coin      <= next_coin;
          eject     <= next_coin;
          pulse_cnt <= 4'd0;
          state     <= PULSE;
        end
        PULSE: begin
          if (pulse_cnt == PULSE_LAST) begin
            eject     <= 3'b000;
            ack_timer <= 8'd0;
            state     <= WAIT_ACK;
          end else begin
            pulse_cnt <= pulse_cnt + 4'd1;
          end
        end
        WAIT_ACK: begin
          if (ack_accepted) begin
            remaining <= remaining_next;
            if (remaining_next == 5'd0) begin
              done  <= 1'b1;
              ready <= 1'b1;
              state <= IDLE;
            end else begin
              state <= SELECT;
            end
          end else if (ack_timer == TIMEOUT_LAST) begin
            fault <= 1'b1;
            state <= FAULT;
          end else begin
            ack_timer <= ack_timer + 8'd1;
          end
        end
        FAULT: begin
          eject <= 3'b000;
          ready <= 1'b0;
          fault <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.change_ready = ready;
  assign bus.eject        = eject;
  assign bus.done         = done;
  assign bus.remaining    = remaining;
  assign bus.fault        = fault;

`ifdef CHANGE_DISP_COUNT_EN
  logic [7:0] q_cnt;
  logic [7:0] d_cnt;
  logic [7:0] n_cnt;

  // Counters saturate rather than wrap so a long-running total never looks small.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_cnt <= 8'd0;
      d_cnt <= 8'd0;
      n_cnt <= 8'd0;
    end else if (ack_accepted) begin
      case (coin)
        3'b100:  if (q_cnt != 8'hFF) q_cnt <= q_cnt + 8'd1;
        3'b010:  if (d_cnt != 8'hFF) d_cnt <= d_cnt + 8'd1;
        default: if (n_cnt != 8'hFF) n_cnt <= n_cnt + 8'd1;
      endcase
    end
  end

  assign bus.q_count = q_cnt;
  assign bus.d_count = d_cnt;
  assign bus.n_count = n_cnt;
`else
  assign bus.q_count = 8'd0;
  assign bus.d_count = 8'd0;
  assign bus.n_count = 8'd0;
`endif

endmodule
